// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, standard IV, sigma/choice/majority
// helpers, working-state packing and the round-engine FSM encoding.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } sha_fsm_t;

  // Working variables; a sits in the MSBs so the struct matches iv_in/state_out packing.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha_state_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // Sigma0 of the compression round
  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  // Sigma1 of the compression round
  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // sigma0 of the message schedule
  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // sigma1 of the message schedule
  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_engine_msg_sched.sv
// SHA-256 message schedule: a 16-word sliding window holding W[t]..W[t+15].
// win[15] is always W[t]; each advance shifts the window and appends the next
// expanded word(s). With SHA_TWO_ROUNDS_EN defined it shifts by two per edge
// and also presents W[t+1].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic [511:0] block_in,
  output logic [31:0]  w0
`ifdef SHA_TWO_ROUNDS_EN
  ,
  output logic [31:0]  w1
`endif
);

  // win[15-j] holds W[t+j]; loading the block directly puts W0 in win[15].
  logic [15:0][31:0] win;
  logic [31:0]       nw0;

  // Next expanded word W[t+16] from the current window.
  always_comb begin
    nw0 = small_s1(win[1]) + win[6] + small_s0(win[14]) + win[15];
  end

`ifdef SHA_TWO_ROUNDS_EN
  logic [31:0] nw1;

  // W[t+17] needs only W[t+15] and older, so it does not depend on nw0.
  always_comb begin
    nw1 = small_s1(win[0]) + win[5] + small_s0(win[13]) + win[14];
  end

  assign w1 = win[14];
`endif

  assign w0 = win[15];

  // Window register: load the block on accept, otherwise slide while rounds run.
  always_ff @(posedge clk) begin
    if (reset) begin
      win <= '0;
    end else if (load) begin
      win <= block_in;
    end else if (advance) begin
`ifdef SHA_TWO_ROUNDS_EN
      win <= {win[13:0], nw0, nw1};
`else
      win <= {win[14:0], nw0};
`endif
    end
  end

endmodule

// File: rtl/sha256_round_engine.sv
// SHA-256 compression round engine: 64 rounds over one block starting from a
// chaining value, returning the final working variables (no IV add).
// Optional build macro SHA_TWO_ROUNDS_EN: two rounds per clock (32-cycle latency).
module sha256_round_engine
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] iv_in,
  input  logic [1:0]   tag_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] state_out,
  output logic [1:0]   tag_out
);

`ifdef SHA_TWO_ROUNDS_EN
  localparam logic [5:0] T_STEP = 6'd2;
  localparam logic [5:0] T_LAST = 6'd62;
`else
  localparam logic [5:0] T_STEP = 6'd1;
  localparam logic [5:0] T_LAST = 6'd63;
`endif

  sha_fsm_t   fsm;
  logic [5:0] t;
  sha_state_t work;
  sha_state_t next_work;
  logic [1:0] tag_q;
  logic       sched_load;
  logic       sched_adv;
  logic [31:0] w0;

  function automatic sha_state_t sha_round(input sha_state_t s, input logic [31:0] k,
                                           input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    sha_state_t  r;
    t1  = s.h + big_s1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2  = big_s0(s.a) + maj(s.a, s.b, s.c);
    r.a = t1 + t2;
    r.b = s.a;
    r.c = s.b;
    r.d = s.c;
    r.e = s.d + t1;
    r.f = s.e;
    r.g = s.f;
    r.h = s.g;
    return r;
  endfunction

  assign sched_load = (fsm == ST_IDLE) && start;
  assign sched_adv  = (fsm == ST_ROUND);

`ifdef SHA_TWO_ROUNDS_EN
  logic [31:0] w1;
  sha_state_t  mid_work;

  sha256_msg_sched u_sched (
    .clk      (clk),
    .reset    (reset),
    .load     (sched_load),
    .advance  (sched_adv),
    .block_in (block_in),
    .w0       (w0),
    .w1       (w1)
  );

  // Rounds t and t+1 chained combinationally; t is always even here.
  always_comb begin
    mid_work  = sha_round(work, K[t], w0);
    next_work = sha_round(mid_work, K[{t[5:1], 1'b1}], w1);
  end
`else
  sha256_msg_sched u_sched (
    .clk      (clk),
    .reset    (reset),
    .load     (sched_load),
    .advance  (sched_adv),
    .block_in (block_in),
    .w0       (w0)
  );

  // Single round t per clock.
  always_comb begin
    next_work = sha_round(work, K[t], w0);
  end
`endif

  // Control FSM with registered busy/done and result capture on DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      t         <= '0;
      work      <= '0;
      tag_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      state_out <= '0;
      tag_out   <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= iv_in;
            tag_q <= tag_in;
            t     <= '0;
            busy  <= 1'b1;
            fsm   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          work <= next_work;
          t    <= t + T_STEP;
          if (t == T_LAST) begin
            fsm       <= ST_DONE;
            done      <= 1'b1;
            state_out <= next_work;
            tag_out   <= tag_q;
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          fsm  <= ST_IDLE;
        end
        default: begin
          fsm  <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
